// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// dhit is combinational; misses stall the pipeline while the victim line is
// written back and/or the requested line is refilled over a line-wide
// req/ready handshake.
module dcache_ctrl #(
  parameter int LINES     = 4,
  parameter int LINE_BITS = 128,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 LoadM,
  input  logic                 MemWriteM,
  input  logic                 ByteM,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 dhit,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ready
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t               state;
  logic [LINE_BITS-1:0] line_q [LINES];
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]     miss_tag;

  logic                 acc;
  logic                 hit;
  logic                 store_hit;
  logic                 fill_done;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     atag;
  logic [IDX_W-1:0]     xfer_idx;
  logic [TAG_W-1:0]     xfer_tag;

  // Lookup, hit detection and same-cycle load data
  always_comb begin
    acc       = LoadM | MemWriteM;
    idx       = addr[4 +: IDX_W];
    atag      = addr[ADDR_W-1 -: TAG_W];
    hit       = valid_q[idx] && (tag_q[idx] == atag);
    dhit      = !acc || ((state == IDLE) && hit);
    rdata     = '0;
    if ((state == IDLE) && hit)
      rdata = line_q[idx][{addr[3:2], 5'b0} +: 32];
    store_hit = MemWriteM && (state == IDLE) && hit && !reset;
    fill_done = (state == FILL) && mem_ready && !reset;
    // The outstanding line address is held in mem_addr, so the fill target
    // is taken from there rather than from the (pipeline-held) request.
    xfer_idx  = mem_addr[4 +: IDX_W];
    xfer_tag  = mem_addr[ADDR_W-1 -: TAG_W];
  end

  // Data and tag arrays: refill a whole line or merge a store hit
  always_ff @(posedge clk) begin
    if (fill_done) begin
      line_q[xfer_idx] <= mem_rdata;
      tag_q[xfer_idx]  <= xfer_tag;
    end else if (store_hit) begin
      if (ByteM)
        line_q[idx][{addr[3:0], 3'b0} +: 8] <= wdata[7:0];
      else
        line_q[idx][{addr[3:2], 5'b0} +: 32] <= wdata;
    end
  end

  // Miss FSM with registered memory interface and valid/dirty bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      miss_tag  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && hit) begin
            if (MemWriteM)
              dirty_q[idx] <= 1'b1;
          end else if (acc) begin
            miss_tag <= atag;
            mem_req  <= 1'b1;
            if (dirty_q[idx]) begin
              state     <= WB;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_q[idx], idx, 4'b0};
              mem_wdata <= line_q[idx];
            end else begin
              state    <= FILL;
              mem_we   <= 1'b0;
              mem_addr <= {atag, idx, 4'b0};
            end
          end
        end
        WB: begin
          if (mem_ready) begin
            dirty_q[xfer_idx] <= 1'b0;
            if (acc) begin
              state    <= FILL;
              mem_we   <= 1'b0;
              mem_addr <= {miss_tag, xfer_idx, 4'b0};
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            valid_q[xfer_idx] <= 1'b1;
            dirty_q[xfer_idx] <= 1'b0;
            state             <= IDLE;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus pushes expected access
// completions and memory transactions; a monitor pops and compares them,
// and a memory responder answers requests with a programmable delay.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         LoadM, MemWriteM, ByteM;
  logic [31:0]  addr, wdata, rdata;
  logic         dhit, mem_req, mem_we, mem_ready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  dcache_ctrl #(.LINES(4), .LINE_BITS(128), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .LoadM(LoadM), .MemWriteM(MemWriteM),
    .ByteM(ByteM), .addr(addr), .wdata(wdata), .rdata(rdata), .dhit(dhit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_mem;
    bit           chk_rd;
    logic [31:0]  rd;
    bit           we;
    logic [31:0]  maddr;
    logic [127:0] wd;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] mem [logic [31:0]];
  int           total = 0;
  int           bad   = 0;
  int           mem_delay = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_mem(input bit we, input logic [31:0] a, input logic [127:0] wd);
    exp_t e;
    e = '{is_mem: 1'b1, chk_rd: 1'b0, rd: '0, we: we, maddr: a, wd: wd};
    exp_q.push_back(e);
  endtask

  // Issue one access, wait for dhit (bounded), then check the stall count
  task automatic access(input bit ld, input bit st, input bit bt,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int stalls_exp, input bit exact);
    exp_t e;
    int   stalls;
    bit   done;
    e = '{is_mem: 1'b0, chk_rd: (ld && !st), rd: exp_rd, we: 1'b0, maddr: '0, wd: '0};
    exp_q.push_back(e);
    LoadM = ld; MemWriteM = st; ByteM = bt; addr = a; wdata = d;
    stalls = 0; done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dhit) begin done = 1; break; end
      stalls++;
    end
    chk("access_done", done, 1'b1);
    if (exact) chk("stall_cycles", stalls, stalls_exp);
    else       chk("stall_at_least", (stalls >= stalls_exp), 1'b1);
    @(posedge clk); #1;
    LoadM = 0; MemWriteM = 0; ByteM = 0;
  endtask

  // Monitor: compare every completed access and memory handshake in order
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (((LoadM | MemWriteM) && dhit) || (mem_req && mem_ready))) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event: got req=%0b we=%0h addr=%0h, expected none",
                   mem_req, mem_we, mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", (mem_req && mem_ready), e.is_mem);
          if (e.is_mem) begin
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.maddr);
            if (e.we) chk("mem_wdata", mem_wdata, e.wd);
          end else if (e.chk_rd) begin
            chk("rdata", rdata, e.rd);
          end
        end
      end
    end
  end

  // Memory responder: hold-stability checks during the delay, then one-cycle ready
  initial begin
    bit           ab, cwe;
    logic [31:0]  ca;
    logic [127:0] cwd;
    mem_ready = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !mem_ready && !reset) begin
        cwe = mem_we; ca = mem_addr; cwd = mem_wdata; ab = 0;
        for (int i = 0; i < mem_delay; i++) begin
          @(negedge clk);
          if (reset) begin ab = 1; break; end
          chk("hold_req", mem_req, 1'b1);
          chk("hold_we", mem_we, cwe);
          chk("hold_addr", mem_addr, ca);
          chk("hold_wdata", mem_wdata, cwd);
        end
        if (!ab) begin
          @(posedge clk); #1;
          mem_ready = 1;
          mem_rdata = mem.exists(ca) ? mem[ca] : '0;
          @(posedge clk); #1;
          if (cwe) mem[ca] = cwd;
          mem_ready = 0; mem_rdata = '0;
        end
      end
    end
  end

  initial begin
    mem[32'h40] = 128'h0C0B0A09_08070605_01020304_44332211;
    mem[32'h80] = 128'h13579BDF_2468ACE0_CAFEF00D_55667788;
    reset = 1; LoadM = 0; MemWriteM = 0; ByteM = 0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Reset state with no request present
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_dhit", dhit, 1'b1);

    // 1: clean miss, fill, replay hit
    exp_mem(0, 32'h40, '0);
    access(1, 0, 0, 32'h40, 0, 32'h44332211, 2, 0);
    // 2: word store hit, then load it back
    access(0, 1, 0, 32'h44, 32'hDEADBEEF, 0, 0, 1);
    access(1, 0, 0, 32'h44, 0, 32'hDEADBEEF, 0, 1);
    // 3: byte store into lane 1
    access(0, 1, 1, 32'h45, 32'h000000AA, 0, 0, 1);
    access(1, 0, 0, 32'h44, 0, 32'hDEADAAEF, 0, 1);
    // 4: dirty eviction by an aliasing address, slow memory
    mem_delay = 3;
    exp_mem(1, 32'h40, 128'h0C0B0A09_08070605_DEADAAEF_44332211);
    exp_mem(0, 32'h80, '0);
    access(1, 0, 0, 32'h80, 0, 32'h55667788, 3, 0);
    access(1, 0, 0, 32'h84, 0, 32'hCAFEF00D, 0, 1);
    mem_delay = 0;
    exp_mem(0, 32'h40, '0);
    access(1, 0, 0, 32'h44, 0, 32'hDEADAAEF, 2, 0);

    // 5: dirty the line, then reset in the middle of another fill
    access(0, 1, 0, 32'h48, 32'h11111111, 0, 0, 1);
    mem_delay = 5;
    LoadM = 1; addr = 32'h90;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fill_req_before_reset", mem_req, 1'b1);
    reset = 1; LoadM = 0;
    @(posedge clk); #1;
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_mem_we", mem_we, 1'b0);
    reset = 0;
    mem_delay = 0;
    exp_mem(0, 32'h40, '0);
    access(1, 0, 0, 32'h48, 0, 32'h08070605, 2, 0);

    // 6: simultaneous load+store on a hit acts as a store
    access(1, 1, 0, 32'h4C, 32'h77777777, 0, 0, 1);
    access(1, 0, 0, 32'h4C, 0, 32'h77777777, 0, 1);

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
